// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment driver: latches a hex word, scans one digit per
// refresh slot, and drives registered active-low segment, decimal-point and anode lines.
module seven_seg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    en,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CNT_W-1:0]        presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dpo_q, dpo_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic       tick;
  logic [3:0] nib;
  logic       dp_sel;
  logic       blank;
  logic       zero_run;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0001100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      default: g = 7'b0111000;
    endcase
    return g;
  endfunction

  always_comb begin
    tick    = (presc_q == CNT_W'(REFRESH_DIV - 1));
    presc_d = tick ? '0 : presc_q + CNT_W'(1);
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    value_d = load ? value_in : value_q;
    dp_d    = load ? dp_in : dp_q;

    // Walk from the top digit down so zero_run says "this digit and all above are zero".
    nib      = 4'h0;
    dp_sel   = 1'b0;
    blank    = 1'b0;
    zero_run = 1'b1;
    an_d     = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (value_q[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        nib    = value_q[4*i +: 4];
        dp_sel = dp_q[i];
        blank  = blank_lz && zero_run && (i != 0);
        an_d[i] = ~en;
      end
    end

    if (en) begin
      seg_d = blank ? 7'b1111111 : glyph(nib);
      dpo_d = ~dp_sel;
    end else begin
      seg_d = 7'b1111111;
      dpo_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      value_q <= '0;
      dp_q    <= '0;
      seg_q   <= 7'b1111111;
      dpo_q   <= 1'b1;
      an_q    <= '1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      value_q <= value_d;
      dp_q    <= dp_d;
      seg_q   <= seg_d;
      dpo_q   <= dpo_d;
      an_q    <= an_d;
    end
  end

  assign seg_out = seg_q;
  assign dp_out  = dpo_q;
  assign an_out  = an_q;

endmodule
